// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use bubble injection, branch flush and data-memory freeze for the 5-stage pipeline
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_RS_i,
  input  logic [4:0]       ID_RT_i,
  input  logic             EX_MemRead_i,
  input  logic [4:0]       EX_Rt_i,
  input  logic             Branch_taken_i,
  input  logic             Dmem_req_i,
  input  logic             Dmem_ack_i,
  output logic             PC_Write_o,
  output logic             IFID_Write_o,
  output logic             IFID_Flush_o,
  output logic             IDEX_Bubble_o,
  output logic             Mem_Stall_o,
  output logic             Mem_Err_o,
  output logic [CNT_W-1:0] Stall_cnt_o
);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  localparam logic [15:0] TO = 16'(MEM_TIMEOUT);
  state_t state, state_nx;
  logic [15:0] waitcnt;
  logic memwait, loaduse, timeout, pc_write;
  always_comb begin
    loaduse = EX_MemRead_i & (EX_Rt_i != 5'd0) & ((EX_Rt_i == ID_RS_i) | (EX_Rt_i == ID_RT_i));
    memwait = (state == RUN) ? Dmem_req_i & ~Dmem_ack_i : ~Dmem_ack_i & (waitcnt < TO);
    timeout = (state == MEM_WAIT) & ~Dmem_ack_i & (waitcnt == TO);
    state_nx = (state == RUN) ? ((Dmem_req_i & ~Dmem_ack_i) ? MEM_WAIT : RUN)
                              : ((Dmem_ack_i | timeout) ? RUN : MEM_WAIT);
    pc_write = ~rst_i & ~memwait & ~loaduse;
    PC_Write_o = pc_write;
    IFID_Write_o = pc_write;
    // a branch alongside a load-use is dropped: its operands are not valid yet
    IFID_Flush_o = pc_write & Branch_taken_i;
    IDEX_Bubble_o = rst_i | (~memwait & loaduse);
    Mem_Stall_o = ~rst_i & memwait;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= RUN;
      waitcnt <= '0;
      Stall_cnt_o <= '0;
      Mem_Err_o <= 1'b0;
    end else begin
      state <= state_nx;
      waitcnt <= (state == RUN) ? '0 : waitcnt + 16'd1;
      Stall_cnt_o <= (~pc_write & ~&Stall_cnt_o) ? Stall_cnt_o + CNT_W'(1) : Stall_cnt_o;
      Mem_Err_o <= Mem_Err_o | timeout;
    end
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: scoreboard bench for hazard_stall_ctrl (MEM_TIMEOUT=4, CNT_W=4)
module tb_hazard_stall_ctrl;
  logic clk = 1'b0, rst_i = 1'b1;
  logic [4:0] ID_RS_i = '0, ID_RT_i = '0, EX_Rt_i = '0;
  logic EX_MemRead_i = 1'b0, Branch_taken_i = 1'b0, Dmem_req_i = 1'b0, Dmem_ack_i = 1'b0;
  logic PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Mem_Stall_o, Mem_Err_o;
  logic [3:0] Stall_cnt_o;
  int n_cmp = 0, n_err = 0;
  localparam logic [4:0] RUNC = 5'b11000, BUB = 5'b00010, BRF = 5'b11100, MST = 5'b00001, RSTC = 5'b00010;
  typedef struct packed {
    logic rst; logic [4:0] rs, rt; logic mr; logic [4:0] ert; logic br, req, ack;
    logic [4:0] ctl; logic [3:0] cnt; logic err;
  } row_t;
  typedef struct packed {logic [4:0] ctl; logic [3:0] cnt; logic err;} exp_t;
  exp_t sb[$];
  hazard_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .ID_RS_i(ID_RS_i), .ID_RT_i(ID_RT_i),
    .EX_MemRead_i(EX_MemRead_i), .EX_Rt_i(EX_Rt_i), .Branch_taken_i(Branch_taken_i),
    .Dmem_req_i(Dmem_req_i), .Dmem_ack_i(Dmem_ack_i), .PC_Write_o(PC_Write_o),
    .IFID_Write_o(IFID_Write_o), .IFID_Flush_o(IFID_Flush_o), .IDEX_Bubble_o(IDEX_Bubble_o),
    .Mem_Stall_o(Mem_Stall_o), .Mem_Err_o(Mem_Err_o), .Stall_cnt_o(Stall_cnt_o)
  );
  always #5 clk = ~clk;
  function automatic row_t r(logic rst, logic [4:0] rs, logic [4:0] rt, logic mr, logic [4:0] ert,
                             logic br, logic req, logic ack, logic [4:0] ctl, logic [3:0] cnt, logic err);
    r = '{rst, rs, rt, mr, ert, br, req, ack, ctl, cnt, err};
  endfunction
  task automatic apply(input row_t x);
    @(negedge clk);
    {rst_i, ID_RS_i, ID_RT_i, EX_MemRead_i, EX_Rt_i, Branch_taken_i, Dmem_req_i, Dmem_ack_i} =
      {x.rst, x.rs, x.rt, x.mr, x.ert, x.br, x.req, x.ack};
    sb.push_back('{x.ctl, x.cnt, x.err});
  endtask
  task automatic do_reset();
    apply(r(1, 0, 0, 0, 0, 0, 0, 0, RSTC, 0, 0));
    void'(sb.pop_front());
    apply(r(1, 0, 0, 0, 0, 0, 0, 0, RSTC, 0, 0));
    void'(sb.pop_front());
  endtask
  task automatic test_reset();
    row_t rows[$];
    exp_t e;
    do_reset();
    rows.push_back(r(1, 0, 0, 0, 0, 1, 1, 0, RSTC, 0, 0));
    rows.push_back(r(1, 9, 0, 1, 9, 0, 1, 0, RSTC, 0, 0));
    rows.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, RUNC, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      #1 e = sb.pop_front();
      n_cmp++;
      if ({PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Mem_Stall_o} !== e.ctl) begin
        n_err++;
        $display("FAIL reset[%0d] ctl got %b exp %b", i, {PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Mem_Stall_o}, e.ctl);
      end
      n_cmp++;
      if ({Stall_cnt_o, Mem_Err_o} !== {e.cnt, e.err}) begin
        n_err++;
        $display("FAIL reset[%0d] cnt/err got %0d/%b exp %0d/%b", i, Stall_cnt_o, Mem_Err_o, e.cnt, e.err);
      end
    end
  endtask
  task automatic test_load_use();
    row_t rows[$];
    exp_t e;
    do_reset();
    rows.push_back(r(0, 9, 3, 1, 9, 0, 0, 0, BUB, 0, 0));
    rows.push_back(r(0, 9, 3, 0, 9, 0, 0, 0, RUNC, 1, 0));
    rows.push_back(r(0, 0, 0, 1, 0, 0, 0, 0, RUNC, 1, 0));
    rows.push_back(r(0, 2, 5, 1, 5, 0, 0, 0, BUB, 1, 0));
    rows.push_back(r(0, 2, 5, 1, 7, 0, 0, 0, RUNC, 2, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      #1 e = sb.pop_front();
      n_cmp++;
      if ({PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Mem_Stall_o} !== e.ctl) begin
        n_err++;
        $display("FAIL load_use[%0d] ctl got %b exp %b", i, {PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Mem_Stall_o}, e.ctl);
      end
      n_cmp++;
      if ({Stall_cnt_o, Mem_Err_o} !== {e.cnt, e.err}) begin
        n_err++;
        $display("FAIL load_use[%0d] cnt/err got %0d/%b exp %0d/%b", i, Stall_cnt_o, Mem_Err_o, e.cnt, e.err);
      end
    end
  endtask
  task automatic test_branch();
    row_t rows[$];
    exp_t e;
    do_reset();
    rows.push_back(r(0, 1, 2, 0, 0, 1, 0, 0, BRF, 0, 0));
    rows.push_back(r(0, 9, 2, 1, 9, 1, 0, 0, BUB, 0, 0));
    rows.push_back(r(0, 9, 2, 0, 9, 1, 0, 0, BRF, 1, 0));
    rows.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, RUNC, 1, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      #1 e = sb.pop_front();
      n_cmp++;
      if ({PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Mem_Stall_o} !== e.ctl) begin
        n_err++;
        $display("FAIL branch[%0d] ctl got %b exp %b", i, {PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Mem_Stall_o}, e.ctl);
      end
      n_cmp++;
      if ({Stall_cnt_o, Mem_Err_o} !== {e.cnt, e.err}) begin
        n_err++;
        $display("FAIL branch[%0d] cnt/err got %0d/%b exp %0d/%b", i, Stall_cnt_o, Mem_Err_o, e.cnt, e.err);
      end
    end
  endtask
  task automatic test_mem_wait();
    row_t rows[$];
    exp_t e;
    do_reset();
    rows.push_back(r(0, 9, 0, 1, 9, 1, 1, 0, MST, 0, 0));
    rows.push_back(r(0, 9, 0, 1, 9, 0, 1, 0, MST, 1, 0));
    rows.push_back(r(0, 9, 0, 1, 9, 0, 1, 0, MST, 2, 0));
    rows.push_back(r(0, 0, 0, 0, 0, 0, 1, 1, RUNC, 3, 0));
    rows.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, RUNC, 3, 0));
    rows.push_back(r(0, 0, 0, 0, 0, 0, 1, 1, RUNC, 3, 0));
    rows.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, RUNC, 3, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      #1 e = sb.pop_front();
      n_cmp++;
      if ({PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Mem_Stall_o} !== e.ctl) begin
        n_err++;
        $display("FAIL mem_wait[%0d] ctl got %b exp %b", i, {PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Mem_Stall_o}, e.ctl);
      end
      n_cmp++;
      if ({Stall_cnt_o, Mem_Err_o} !== {e.cnt, e.err}) begin
        n_err++;
        $display("FAIL mem_wait[%0d] cnt/err got %0d/%b exp %0d/%b", i, Stall_cnt_o, Mem_Err_o, e.cnt, e.err);
      end
    end
  endtask
  task automatic test_timeout();
    row_t rows[$];
    exp_t e;
    do_reset();
    for (int k = 0; k < 5; k++) rows.push_back(r(0, 0, 0, 0, 0, 0, 1, 0, MST, 4'(k), 0));
    rows.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, RUNC, 5, 0));
    rows.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, RUNC, 5, 1));
    rows.push_back(r(0, 0, 0, 0, 0, 0, 1, 0, MST, 5, 1));
    rows.push_back(r(0, 0, 0, 0, 0, 0, 1, 1, RUNC, 6, 1));
    rows.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, RUNC, 6, 1));
    foreach (rows[i]) begin
      apply(rows[i]);
      #1 e = sb.pop_front();
      n_cmp++;
      if ({PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Mem_Stall_o} !== e.ctl) begin
        n_err++;
        $display("FAIL timeout[%0d] ctl got %b exp %b", i, {PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Mem_Stall_o}, e.ctl);
      end
      n_cmp++;
      if ({Stall_cnt_o, Mem_Err_o} !== {e.cnt, e.err}) begin
        n_err++;
        $display("FAIL timeout[%0d] cnt/err got %0d/%b exp %0d/%b", i, Stall_cnt_o, Mem_Err_o, e.cnt, e.err);
      end
    end
  endtask
  task automatic test_reset_mid_wait();
    row_t rows[$];
    exp_t e;
    rows.push_back(r(0, 0, 0, 0, 0, 0, 1, 0, MST, 6, 1));
    rows.push_back(r(0, 0, 0, 0, 0, 0, 1, 0, MST, 7, 1));
    rows.push_back(r(1, 0, 0, 0, 0, 0, 1, 0, RSTC, 8, 1));
    rows.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, RUNC, 0, 0));
    rows.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, RUNC, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      #1 e = sb.pop_front();
      n_cmp++;
      if ({PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Mem_Stall_o} !== e.ctl) begin
        n_err++;
        $display("FAIL reset_mid_wait[%0d] ctl got %b exp %b", i, {PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Mem_Stall_o}, e.ctl);
      end
      n_cmp++;
      if ({Stall_cnt_o, Mem_Err_o} !== {e.cnt, e.err}) begin
        n_err++;
        $display("FAIL reset_mid_wait[%0d] cnt/err got %0d/%b exp %0d/%b", i, Stall_cnt_o, Mem_Err_o, e.cnt, e.err);
      end
    end
  endtask
  task automatic test_saturation();
    row_t rows[$];
    exp_t e;
    do_reset();
    for (int k = 0; k < 20; k++) rows.push_back(r(0, 0, 12, 1, 12, 0, 0, 0, BUB, 4'(k > 15 ? 15 : k), 0));
    rows.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, RUNC, 15, 0));
    rows.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, RUNC, 15, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      #1 e = sb.pop_front();
      n_cmp++;
      if ({PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Mem_Stall_o} !== e.ctl) begin
        n_err++;
        $display("FAIL saturation[%0d] ctl got %b exp %b", i, {PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Mem_Stall_o}, e.ctl);
      end
      n_cmp++;
      if ({Stall_cnt_o, Mem_Err_o} !== {e.cnt, e.err}) begin
        n_err++;
        $display("FAIL saturation[%0d] cnt/err got %0d/%b exp %0d/%b", i, Stall_cnt_o, Mem_Err_o, e.cnt, e.err);
      end
    end
  endtask
  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline stall and flush controller for the 5-stage MIPS core. It is the producer side of hazard resolution: the forwarding unit resolves hazards by steering ALU operands, and this block resolves the hazards forwarding cannot cover. It detects load-use hazards between ID and EX and injects a one-cycle bubble. It flushes IF/ID on taken branches resolved in ID. It freezes the whole pipeline while a multi-cycle data-memory access is outstanding, with a timeout guard and stall-cycle statistics.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before forced release; legal range 1..65535
- CNT_W, 16: width of the stall statistics counter

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset; synchronous, active-high
- ID_RS_i  input  5  rs field of the instruction in ID
- ID_RT_i  input  5  rt field of the instruction in ID
- EX_MemRead_i  input  1  instruction in EX is a load
- EX_Rt_i  input  5  load destination register in EX
- Branch_taken_i  input  1  branch in ID resolved taken this cycle
- Dmem_req_i  input  1  instruction in MEM is accessing data memory
- Dmem_ack_i  input  1  data memory completes the access this cycle
- PC_Write_o  output  1  PC update enable
- IFID_Write_o  output  1  IF/ID register write enable
- IFID_Flush_o  output  1  zero IF/ID on the next edge
- IDEX_Bubble_o  output  1  load NOP control bits into ID/EX
- Mem_Stall_o  output  1  hold ID/EX, EX/MEM and MEM/WB contents
- Mem_Err_o  output  1  sticky flag: a memory access hit the timeout
- Stall_cnt_o  output  CNT_W  saturating count of cycles with PC_Write_o=0

## Operation
- States: RUN and MEM_WAIT. A wait counter is cleared on every entry to MEM_WAIT.
- Conditions (combinational):
  - memwait: in RUN, Dmem_req_i & ~Dmem_ack_i. In MEM_WAIT, ~Dmem_ack_i & (waitcnt < MEM_TIMEOUT).
  - loaduse: EX_MemRead_i & (EX_Rt_i != 0) & ((EX_Rt_i == ID_RS_i) | (EX_Rt_i == ID_RT_i)).
- Priority is memwait > loaduse > branch.
- memwait: Mem_Stall_o=1, PC_Write_o=0, IFID_Write_o=0, IDEX_Bubble_o=0, IFID_Flush_o=0. Loaduse and branch are ignored; the held instructions re-evaluate after release.
- loaduse (no memwait): PC_Write_o=0, IFID_Write_o=0, IDEX_Bubble_o=1, IFID_Flush_o=0. A simultaneous Branch_taken_i is suppressed, because the branch operands are not yet valid.
- branch only: IFID_Flush_o=1, PC_Write_o=1, IFID_Write_o=1.
- No condition: PC_Write_o=1, IFID_Write_o=1, all other control outputs 0.
- Transitions:
  - RUN -> MEM_WAIT when Dmem_req_i & ~Dmem_ack_i.
  - MEM_WAIT -> RUN on Dmem_ack_i.
  - MEM_WAIT -> RUN on timeout (waitcnt == MEM_TIMEOUT without ack). Mem_Err_o sets and stays set until reset. The pipeline is released in that same cycle.
- waitcnt increments each cycle in MEM_WAIT without ack.
- Stall_cnt_o increments each cycle PC_Write_o=0 and sticks at all ones.
- Reset (rst_i high, any state, including mid-MEM_WAIT):
  - Next state RUN; waitcnt=0, Stall_cnt_o=0, Mem_Err_o=0.
  - While rst_i is high: PC_Write_o=0, IFID_Write_o=0, IDEX_Bubble_o=1, IFID_Flush_o=0, Mem_Stall_o=0.
  - Reset cycles do not count toward Stall_cnt_o.

## Timing
- All control outputs are combinational from state and inputs, and valid in the same cycle as the triggering inputs.
- Pipeline registers act on the following rising edge.
- A load-use stall lasts exactly 1 cycle. After the bubble the load is in MEM, so the condition clears.
- Memory stall lasts from the request cycle through the cycle before ack. On the ack cycle Mem_Stall_o=0 and the pipeline advances. An ack in the request cycle gives zero stall cycles.
- On timeout, MEM_TIMEOUT+1 stalled cycles are counted (request cycle plus MEM_TIMEOUT wait cycles). Mem_Err_o is visible from the next edge.
- Stall_cnt_o and Mem_Err_o are registered and update 1 edge after the counted cycle.

## Test plan
- Load-use hazard: lw $t1 in EX (EX_MemRead_i=1, EX_Rt_i=9), ID_RS_i=9 -> exactly 1 cycle of PC_Write_o=0, IFID_Write_o=0, IDEX_Bubble_o=1; Stall_cnt_o goes 0->1. Repeat with EX_Rt_i=0 -> no stall.
- Branch with and without conflict: Branch_taken_i=1 with no hazard -> IFID_Flush_o=1, PC_Write_o=1. Same with a load-use match -> flush 0 and bubble 1; next cycle, with the hazard cleared, flush=1.
- Memory wait: Dmem_req_i=1 with ack after 3 more cycles -> Mem_Stall_o=1 for 3 cycles, 0 on the ack cycle; Stall_cnt_o=3; a simultaneous load-use produces no bubble during the stall.
- Timeout: MEM_TIMEOUT=4, req held, ack never asserted -> 5 stalled cycles, then release; Mem_Err_o=1 and stays 1; state returns to RUN.
- Reset mid-wait: assert rst_i in the second MEM_WAIT cycle -> next cycle state RUN, Stall_cnt_o=0, Mem_Err_o=0; PC_Write_o=0 and IDEX_Bubble_o=1 while rst_i is high.
- Saturation: CNT_W=4, 20 consecutive stall cycles -> Stall_cnt_o holds at 15.
